// File: rtl/alloc_arbiter_pkg.sv
// Shared configuration for the allocator arbiter: requester count, id width, FSM states.
// Requester k allocates with config id k, so ids span 0..N_ICFG-1.
package alloc_arbiter_pkg;

  localparam int N_ICFG     = 4;
  localparam int ICFG_ID_BW = $clog2(N_ICFG + 1);
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_BW     = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } alloc_arb_state_t;

endpackage

// File: rtl/alloc_arbiter_if.sv
// Bundle between alloc_arbiter and its environment: requesters, block-end handshake, Allocator, consumer.
// master = the arbiter side, slave = everything around it.
interface alloc_arbiter_if
  import alloc_arbiter_pkg::*;
#(
  parameter int N_REQ  = N_ICFG,
  parameter int ID_BW  = ICFG_ID_BW,
  parameter int CNT_BW = alloc_arbiter_pkg::CNT_BW
);
  logic [N_REQ-1:0]  req_rdy;
  logic [N_REQ-1:0]  req_ack;
  logic              end_rdy;
  logic              end_ack;
  logic              alloc_rdy;
  logic              alloc_ack;
  logic [ID_BW-1:0]  o_alloc_id;
  logic              consume_dval;
  logic              free_dval;
  logic [ID_BW-1:0]  o_free_id;
  logic              blkdone_dval;
  logic [CNT_BW-1:0] o_cnt;

  modport master (
    input  req_rdy, end_rdy, alloc_ack, consume_dval,
    output req_ack, end_ack, alloc_rdy, o_alloc_id, free_dval, o_free_id, blkdone_dval, o_cnt
  );

  modport slave (
    output req_rdy, end_rdy, alloc_ack, consume_dval,
    input  req_ack, end_ack, alloc_rdy, o_alloc_id, free_dval, o_free_id, blkdone_dval, o_cnt
  );

endinterface

// File: rtl/alloc_arbiter_id_fifo.sv
// In-order id FIFO: head/count/full/empty are registered-state views, push/pop take effect at the edge.
// Push while full and pop while empty are dropped; simultaneous push+pop keeps the count.
module alloc_arbiter_id_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         push_i,
  input  logic [W-1:0]                 push_dat_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   cnt_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Depth is a power of two, so pointer increments wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/alloc_arbiter.sv
// Round-robin share of one Allocator among N_REQ requesters; grant 1 cycle after req_rdy, one issue per 2 cycles.
// Grants stall while the outstanding-id FIFO is full or the block is draining; frees are issued in alloc order.
module alloc_arbiter
  import alloc_arbiter_pkg::*;
#(
  parameter int N_REQ      = N_ICFG,
  parameter int FIFO_DEPTH = alloc_arbiter_pkg::FIFO_DEPTH
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  alloc_arbiter_if.master      bus
);

  localparam int ID_BW = $clog2(N_REQ + 1);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  alloc_arb_state_t state_q, state_d;
  logic             alloc_rdy_q, alloc_rdy_d;
  logic [ID_BW-1:0] alloc_id_q, alloc_id_d;
  logic [ID_BW-1:0] rr_q, rr_d;
  logic             free_q, free_d;
  logic [ID_BW-1:0] free_id_q, free_id_d;
  logic             blkdone_q, blkdone_d;
  logic             end_ack_q, end_ack_d;

  logic             push;
  logic             pop;
  logic [ID_BW-1:0] head;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             empty;

  function automatic logic [ID_BW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [ID_BW-1:0] ptr);
    logic [ID_BW-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        pick  = ID_BW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign push = alloc_rdy_q && bus.alloc_ack;
  assign pop  = bus.consume_dval && !empty;

  always_comb begin
    bus.req_ack = '0;
    if (push) bus.req_ack[alloc_id_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    alloc_rdy_d = alloc_rdy_q;
    alloc_id_d  = alloc_id_q;
    rr_d        = rr_q;
    free_d      = 1'b0;
    free_id_d   = free_id_q;
    blkdone_d   = 1'b0;
    end_ack_d   = 1'b0;

    if (push) begin
      alloc_rdy_d = 1'b0;
      rr_d        = (int'(alloc_id_q) == N_REQ - 1) ? '0 : alloc_id_q + 1'b1;
    end
    if (pop) begin
      free_d    = 1'b1;
      free_id_d = head;
    end

    case (state_q)
      RUN: begin
        // end_rdy is still high in the end_ack cycle; don't re-enter DRAIN on it.
        if (bus.end_rdy && !alloc_rdy_q && !end_ack_q) begin
          state_d = DRAIN;
        end else if (!alloc_rdy_q && |bus.req_rdy && !full) begin
          alloc_rdy_d = 1'b1;
          alloc_id_d  = rr_pick(bus.req_rdy, rr_q);
        end
      end
      DRAIN: begin
        // Empty implies no pop this cycle, so blkdone cannot land on a free pulse.
        if (empty) begin
          blkdone_d = 1'b1;
          end_ack_d = 1'b1;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= RUN;
      alloc_rdy_q <= 1'b0;
      alloc_id_q  <= '0;
      rr_q        <= '0;
      free_q      <= 1'b0;
      free_id_q   <= '0;
      blkdone_q   <= 1'b0;
      end_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alloc_rdy_q <= alloc_rdy_d;
      alloc_id_q  <= alloc_id_d;
      rr_q        <= rr_d;
      free_q      <= free_d;
      free_id_q   <= free_id_d;
      blkdone_q   <= blkdone_d;
      end_ack_q   <= end_ack_d;
    end
  end

  alloc_arbiter_id_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ID_BW)
  ) u_id_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .push_i     (push),
    .push_dat_i (alloc_id_q),
    .pop_i      (pop),
    .head_o     (head),
    .cnt_o      (cnt),
    .full_o     (full),
    .empty_o    (empty)
  );

  assign bus.alloc_rdy    = alloc_rdy_q;
  assign bus.o_alloc_id   = alloc_id_q;
  assign bus.free_dval    = free_q;
  assign bus.o_free_id    = free_id_q;
  assign bus.blkdone_dval = blkdone_q;
  assign bus.end_ack      = end_ack_q;
  assign bus.o_cnt        = cnt;

endmodule

// File: tb/tb_alloc_arbiter.sv
// Directed bench for alloc_arbiter (N_REQ=4, depth 8): round-robin grants, lock, full, push+pop, drain, async reset.
module tb_alloc_arbiter;
  import alloc_arbiter_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alloc_arbiter_if #(.N_REQ(4), .ID_BW(3), .CNT_BW(4)) bus ();

  alloc_arbiter #(.N_REQ(4), .FIFO_DEPTH(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".alloc_rdy"}, 32'(bus.alloc_rdy),    32'd0);
    chk({tag, ".alloc_id"},  32'(bus.o_alloc_id),   32'd0);
    chk({tag, ".free"},      32'(bus.free_dval),    32'd0);
    chk({tag, ".free_id"},   32'(bus.o_free_id),    32'd0);
    chk({tag, ".blkdone"},   32'(bus.blkdone_dval), 32'd0);
    chk({tag, ".end_ack"},   32'(bus.end_ack),      32'd0);
    chk({tag, ".cnt"},       32'(bus.o_cnt),        32'd0);
    chk({tag, ".req_ack"},   32'(bus.req_ack),      32'd0);
  endtask

  logic [2:0] id_t1  [4] = '{3'd1, 3'd3, 3'd1, 3'd3};
  logic [2:0] id_t3  [3] = '{3'd2, 3'd0, 3'd2};
  logic [2:0] free_t3[5] = '{3'd3, 3'd1, 3'd3, 3'd1, 3'd2};

  initial begin
    checks           = 0;
    errors           = 0;
    rst_n            = 1'b0;
    bus.req_rdy      = '0;
    bus.end_rdy      = 1'b0;
    bus.alloc_ack    = 1'b1;
    bus.consume_dval = 1'b0;
    tick();
    tick();
    chk_reset_outputs("rst");

    // 1) req_rdy=1010, alloc_ack tied high: grants alternate 1,3 from rr=0
    rst_n       = 1'b1;
    bus.req_rdy = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1.alloc_rdy", 32'(bus.alloc_rdy), 32'd1);
      chk("t1.id",        32'(bus.o_alloc_id), 32'(id_t1[k]));
      chk("t1.req_ack",   32'(bus.req_ack),   32'(4'b0001 << id_t1[k]));
      tick();
      chk("t1.rdy_low",   32'(bus.alloc_rdy), 32'd0);
      chk("t1.cnt",       32'(bus.o_cnt),     32'(k + 1));
    end

    // 2) grant locked while alloc_ack is low
    bus.alloc_ack = 1'b0;
    tick();
    chk("t2.alloc_rdy", 32'(bus.alloc_rdy), 32'd1);
    chk("t2.id",        32'(bus.o_alloc_id), 32'd1);
    for (int k = 0; k < 5; k++) begin
      bus.req_rdy = bus.req_rdy ^ 4'b0001;
      tick();
      chk("t2.hold_rdy", 32'(bus.alloc_rdy), 32'd1);
      chk("t2.hold_id",  32'(bus.o_alloc_id), 32'd1);
      chk("t2.no_ack",   32'(bus.req_ack),   32'd0);
    end
    bus.req_rdy   = '0;
    bus.alloc_ack = 1'b1;
    #1;
    chk("t2.req_ack", 32'(bus.req_ack), 32'b0010);
    tick();
    chk("t2.cnt", 32'(bus.o_cnt), 32'd5);

    // 3) fill to depth 8 with rr wrapping over req_rdy=0101, then stall while full
    bus.req_rdy = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3.id",  32'(bus.o_alloc_id), 32'(id_t3[k]));
      tick();
      chk("t3.cnt", 32'(bus.o_cnt), 32'(6 + k));
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3.full_rdy", 32'(bus.alloc_rdy), 32'd0);
      chk("t3.full_cnt", 32'(bus.o_cnt),     32'd8);
    end
    bus.consume_dval = 1'b1;
    tick();
    bus.consume_dval = 1'b0;
    chk("t3.free",      32'(bus.free_dval), 32'd1);
    chk("t3.free_id",   32'(bus.o_free_id), 32'd1);
    chk("t3.cnt7",      32'(bus.o_cnt),     32'd7);
    chk("t3.still_low", 32'(bus.alloc_rdy), 32'd0);
    tick();
    chk("t3.resume",    32'(bus.alloc_rdy), 32'd1);
    chk("t3.resume_id", 32'(bus.o_alloc_id), 32'd0);
    chk("t3.free_end",  32'(bus.free_dval), 32'd0);
    tick();
    chk("t3.refull", 32'(bus.o_cnt), 32'd8);
    bus.alloc_ack    = 1'b0;
    bus.req_rdy      = '0;
    bus.consume_dval = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3.order_vld", 32'(bus.free_dval), 32'd1);
      chk("t3.order_id",  32'(bus.o_free_id), 32'(free_t3[k]));
    end
    bus.consume_dval = 1'b0;
    chk("t3.cnt3", 32'(bus.o_cnt), 32'd3);

    // 4) push and pop in the same cycle at count 3; FIFO holds 0,2,0
    bus.req_rdy = 4'b1000;
    tick();
    chk("t4.id", 32'(bus.o_alloc_id), 32'd3);
    bus.req_rdy      = '0;
    bus.alloc_ack    = 1'b1;
    bus.consume_dval = 1'b1;
    #1;
    chk("t4.req_ack", 32'(bus.req_ack), 32'b1000);
    tick();
    bus.alloc_ack    = 1'b0;
    bus.consume_dval = 1'b0;
    chk("t4.cnt",     32'(bus.o_cnt),     32'd3);
    chk("t4.free",    32'(bus.free_dval), 32'd1);
    chk("t4.free_id", 32'(bus.o_free_id), 32'd0);

    // 5) end-of-block with 2 outstanding (FIFO 2,0,3 -> pop 2 first)
    bus.consume_dval = 1'b1;
    tick();
    bus.consume_dval = 1'b0;
    chk("t5.pre_id",  32'(bus.o_free_id), 32'd2);
    chk("t5.pre_cnt", 32'(bus.o_cnt),     32'd2);
    bus.end_rdy   = 1'b1;
    bus.req_rdy   = 4'b1111;
    bus.alloc_ack = 1'b1;
    tick();
    chk("t5.no_grant", 32'(bus.alloc_rdy), 32'd0);
    tick();
    chk("t5.no_grant2", 32'(bus.alloc_rdy),    32'd0);
    chk("t5.no_done",   32'(bus.blkdone_dval), 32'd0);
    bus.consume_dval = 1'b1;
    tick();
    chk("t5.free0_id", 32'(bus.o_free_id),    32'd0);
    chk("t5.cnt1",     32'(bus.o_cnt),        32'd1);
    tick();
    bus.consume_dval = 1'b0;
    chk("t5.free1_vld", 32'(bus.free_dval),    32'd1);
    chk("t5.free1_id",  32'(bus.o_free_id),    32'd3);
    chk("t5.cnt0",      32'(bus.o_cnt),        32'd0);
    chk("t5.done_wait", 32'(bus.blkdone_dval), 32'd0);
    tick();
    chk("t5.blkdone",   32'(bus.blkdone_dval), 32'd1);
    chk("t5.end_ack",   32'(bus.end_ack),      32'd1);
    chk("t5.no_free",   32'(bus.free_dval),    32'd0);
    chk("t5.rdy_done",  32'(bus.alloc_rdy),    32'd0);
    tick();
    bus.end_rdy = 1'b0;
    chk("t5.done_end",  32'(bus.blkdone_dval), 32'd0);
    chk("t5.ack_end",   32'(bus.end_ack),      32'd0);
    chk("t5.regrant",   32'(bus.alloc_rdy),    32'd1);
    chk("t5.regrant_id", 32'(bus.o_alloc_id),  32'd0);
    for (int k = 0; k < 5; k++) tick();
    chk("t5.cnt3", 32'(bus.o_cnt), 32'd3);
    bus.end_rdy   = 1'b1;
    bus.req_rdy   = '0;
    bus.alloc_ack = 1'b0;
    tick();
    chk("t5.drain_rdy", 32'(bus.alloc_rdy), 32'd0);

    // 6) async reset mid-DRAIN with 3 outstanding
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("t6");
    bus.end_rdy = 1'b0;
    tick();
    rst_n            = 1'b1;
    bus.consume_dval = 1'b1;
    tick();
    chk("t6.no_free", 32'(bus.free_dval), 32'd0);
    chk("t6.cnt",     32'(bus.o_cnt),     32'd0);
    tick();
    bus.consume_dval = 1'b0;
    chk("t6.no_free2", 32'(bus.free_dval),    32'd0);
    chk("t6.no_done",  32'(bus.blkdone_dval), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
